// File: rtl/stage_ex_muldiv.sv
// stage_ex_muldiv
//   Execute stage: operand forwarding, ALUSrc mux, base ALU, branch target,
//   and an iterative RV32M/RV64M multiply/divide unit.
//
//   Multiplication uses shift-add and division uses restoring division. Both
//   work on operand magnitudes and retire BITS_PER_CYCLE bits per cycle. The
//   sign of the result is fixed up combinationally in the DONE cycle.
//
// Ports
//   clk, rst_n             : rising-edge clock, asynchronous active-low reset
//   ex_flush               : kill the instruction currently in EX
//   id_ex_*                : decoded instruction fields from the ID/EX register
//   forward_a/b            : 00/11 regfile, 01 EX/MEM, 10 WB
//   ex_mem_alu_result_fwd,
//   wb_write_data_fwd      : forwarding sources
//   ex_alu_result          : base ALU result, or M result in the DONE cycle
//   ex_zero_flag           : ex_alu_result == 0
//   ex_branch_target_addr  : id_ex_pc + id_ex_immediate
//   ex_write_data_mem      : forwarded operand B, taken before the ALUSrc mux
//   ex_stall               : hold PC, IF/ID and ID/EX; bubble into EX/MEM
//
// Stall handshake: while ex_stall is 1, the instruction in ID/EX is not
// consumed and must be held unchanged. A cycle with id_ex_valid=1 and
// ex_stall=0 is the cycle in which that instruction advances into EX/MEM.
// An M op therefore advances in its DONE cycle. The following instruction is
// presented in the next cycle, when the FSM is back in IDLE.
module stage_ex_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit ENABLE_M       = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_flush,
  input  logic            id_ex_valid,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [XLEN-1:0] id_ex_read_data_1,
  input  logic [XLEN-1:0] id_ex_read_data_2,
  input  logic [XLEN-1:0] id_ex_immediate,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic            id_ex_alusrc,
  input  logic [1:0]      id_ex_aluop,
  input  logic [6:0]      id_ex_funct7,
  input  logic [2:0]      id_ex_funct3,
  input  logic [XLEN-1:0] ex_mem_alu_result_fwd,
  input  logic [XLEN-1:0] wb_write_data_fwd,
  output logic [XLEN-1:0] ex_alu_result,
  output logic            ex_zero_flag,
  output logic [XLEN-1:0] ex_branch_target_addr,
  output logic [XLEN-1:0] ex_write_data_mem,
  output logic            ex_stall
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);
  localparam int SHW   = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // multiplier->product low / dividend->quotient
  logic [XLEN-1:0]   mag_b_q, mag_b_d; // multiplicand or divisor magnitude
  logic [2:0]        funct3_q, funct3_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;

  // Forwarding and base ALU
  logic [XLEN-1:0] op_a, op_b, alu_in2, alu_res, alu_sra;
  logic [SHW-1:0]  shamt;

  always_comb begin
    case (forward_a)
      2'b01:   op_a = ex_mem_alu_result_fwd;
      2'b10:   op_a = wb_write_data_fwd;
      default: op_a = id_ex_read_data_1;
    endcase
    case (forward_b)
      2'b01:   op_b = ex_mem_alu_result_fwd;
      2'b10:   op_b = wb_write_data_fwd;
      default: op_b = id_ex_read_data_2;
    endcase
  end

  assign alu_in2 = id_ex_alusrc ? id_ex_immediate : op_b;
  assign shamt   = alu_in2[SHW-1:0];
  assign alu_sra = $signed(op_a) >>> shamt;

  // aluop: 00 add (load/store), 01 sub (branch compare), 10 R-type, 11 I-type.
  // Only R-type takes SUB from funct7[5]; SRA/SRAI use it in both.
  always_comb begin
    alu_res = '0;
    case (id_ex_aluop)
      2'b00: alu_res = op_a + alu_in2;
      2'b01: alu_res = op_a - alu_in2;
      default: begin
        case (id_ex_funct3)
          3'b000: alu_res = (id_ex_aluop == 2'b10 && id_ex_funct7[5]) ? op_a - alu_in2
                                                                      : op_a + alu_in2;
          3'b001: alu_res = op_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_in2))};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, (op_a < alu_in2)};
          3'b100: alu_res = op_a ^ alu_in2;
          3'b101: alu_res = id_ex_funct7[5] ? alu_sra : (op_a >> shamt);
          3'b110: alu_res = op_a | alu_in2;
          default: alu_res = op_a & alu_in2;
        endcase
      end
    endcase
  end

  // M-op issue decode. Reset also blocks issue, so ex_stall drops as soon as
  // rst_n falls even if ID/EX still holds an M op.
  logic            m_op, a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  assign m_op = ENABLE_M && rst_n && id_ex_valid && (id_ex_aluop == 2'b10) &&
                (id_ex_funct7 == 7'b0000001) && !ex_flush;

  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  assign a_signed = (id_ex_funct3 == 3'b001) || (id_ex_funct3 == 3'b010) ||
                    (id_ex_funct3 == 3'b100) || (id_ex_funct3 == 3'b110);
  assign b_signed = (id_ex_funct3 == 3'b001) || (id_ex_funct3 == 3'b100) ||
                    (id_ex_funct3 == 3'b110);
  assign sa       = a_signed & op_a[XLEN-1];
  assign sb       = b_signed & op_b[XLEN-1];
  assign mag_a    = sa ? -op_a : op_a;
  assign mag_b    = sb ? -op_b : op_b;
  assign div_zero = id_ex_funct3[2] && (op_b == '0);
  assign div_ovf  = id_ex_funct3[2] && !id_ex_funct3[0] &&
                    (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  // One RUN cycle: BITS_PER_CYCLE unrolled radix-2 steps
  logic [XLEN-1:0] it_hi, it_lo;
  logic [XLEN:0]   rem_sh, trial, sum;

  always_comb begin
    it_hi  = hi_q;
    it_lo  = lo_q;
    rem_sh = '0;
    trial  = '0;
    sum    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (funct3_q[2]) begin
        // Restoring divide: keep the subtraction only if it did not borrow.
        rem_sh = {it_hi, it_lo[XLEN-1]};
        trial  = rem_sh - {1'b0, mag_b_q};
        it_lo  = {it_lo[XLEN-2:0], ~trial[XLEN]};
        it_hi  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
      end else begin
        // Shift-add multiply, LSB first: the product shifts in from the top.
        sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, mag_b_q} : {(XLEN+1){1'b0}});
        it_lo = {sum[0], it_lo[XLEN-1:1]};
        it_hi = sum[XLEN:1];
      end
    end
  end

  // FSM next state, datapath loads and stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mag_b_d  = mag_b_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    ex_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_op) begin
          ex_stall = 1'b1;
          funct3_d = id_ex_funct3;
          mag_b_d  = mag_b;
          if (div_zero) begin
            // The final result is already known: quotient all ones,
            // remainder equals the dividend.
            lo_d     = '1;
            hi_d     = op_a;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            lo_d     = op_a;
            hi_d     = '0;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            lo_d     = mag_a;
            hi_d     = '0;
            sign_a_d = sa;
            sign_b_d = sb;
            cnt_d    = CNT_W'(N - 1);
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (ex_flush) begin
          state_d = S_IDLE;
        end else begin
          ex_stall = 1'b1;
          hi_d     = it_hi;
          lo_d     = it_lo;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_b_q  <= '0;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_b_q  <= mag_b_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  // Sign correction of the latched magnitude result
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0]   m_res;
  logic              neg_res;

  assign prod    = {hi_q, lo_q};
  assign neg_res = sign_a_q ^ sign_b_q;
  assign prod_c  = neg_res ? -prod : prod;

  always_comb begin
    case (funct3_q)
      3'b000:          m_res = lo_q;
      3'b001, 3'b010,
      3'b011:          m_res = prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:  m_res = neg_res ? -lo_q : lo_q;
      default:         m_res = sign_a_q ? -hi_q : hi_q;
    endcase
  end

  assign ex_alu_result         = (state_q == S_DONE && !ex_flush) ? m_res : alu_res;
  assign ex_zero_flag          = (ex_alu_result == '0);
  assign ex_branch_target_addr = id_ex_pc + id_ex_immediate;
  assign ex_write_data_mem     = op_b;

endmodule

// File: tb/tb_stage_ex_muldiv.sv
module tb_stage_ex_muldiv;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            ex_flush;
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_read_data_1;
  logic [XLEN-1:0] id_ex_read_data_2;
  logic [XLEN-1:0] id_ex_immediate;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic            id_ex_alusrc;
  logic [1:0]      id_ex_aluop;
  logic [6:0]      id_ex_funct7;
  logic [2:0]      id_ex_funct3;
  logic [XLEN-1:0] ex_mem_alu_result_fwd;
  logic [XLEN-1:0] wb_write_data_fwd;
  logic [XLEN-1:0] ex_alu_result, ex_branch_target_addr, ex_write_data_mem;
  logic            ex_zero_flag, ex_stall;
  logic [XLEN-1:0] ex_alu_result4, ex_branch_target_addr4, ex_write_data_mem4;
  logic            ex_zero_flag4, ex_stall4;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [XLEN-1:0] exp_q[$];

  stage_ex_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(1), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ex_flush(ex_flush), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .id_ex_read_data_1(id_ex_read_data_1),
    .id_ex_read_data_2(id_ex_read_data_2), .id_ex_immediate(id_ex_immediate),
    .forward_a(forward_a), .forward_b(forward_b), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_aluop(id_ex_aluop), .id_ex_funct7(id_ex_funct7), .id_ex_funct3(id_ex_funct3),
    .ex_mem_alu_result_fwd(ex_mem_alu_result_fwd), .wb_write_data_fwd(wb_write_data_fwd),
    .ex_alu_result(ex_alu_result), .ex_zero_flag(ex_zero_flag),
    .ex_branch_target_addr(ex_branch_target_addr), .ex_write_data_mem(ex_write_data_mem),
    .ex_stall(ex_stall)
  );

  stage_ex_muldiv #(.XLEN(XLEN), .BITS_PER_CYCLE(4), .ENABLE_M(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .ex_flush(ex_flush), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .id_ex_read_data_1(id_ex_read_data_1),
    .id_ex_read_data_2(id_ex_read_data_2), .id_ex_immediate(id_ex_immediate),
    .forward_a(forward_a), .forward_b(forward_b), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_aluop(id_ex_aluop), .id_ex_funct7(id_ex_funct7), .id_ex_funct3(id_ex_funct3),
    .ex_mem_alu_result_fwd(ex_mem_alu_result_fwd), .wb_write_data_fwd(wb_write_data_fwd),
    .ex_alu_result(ex_alu_result4), .ex_zero_flag(ex_zero_flag4),
    .ex_branch_target_addr(ex_branch_target_addr4), .ex_write_data_mem(ex_write_data_mem4),
    .ex_stall(ex_stall4)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: RV32M arithmetic on 64-bit integers
  function automatic logic [XLEN-1:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stall(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Drivers
  task automatic drive_instr(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b, input logic src,
                             input logic [31:0] imm, input logic [31:0] pc);
    id_ex_valid       = 1'b1;
    id_ex_aluop       = aluop;
    id_ex_funct7      = f7;
    id_ex_funct3      = f3;
    id_ex_read_data_1 = a;
    id_ex_read_data_2 = b;
    id_ex_alusrc      = src;
    id_ex_immediate   = imm;
    id_ex_pc          = pc;
    forward_a         = 2'b00;
    forward_b         = 2'b00;
  endtask

  task automatic run_alu(input string tag, input logic [1:0] aluop, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] exp);
    drive_instr(aluop, f7, f3, a, b, src, imm, pc);
    @(negedge clk);
    check({tag, "_res"},    ex_alu_result, exp);
    check({tag, "_stall"},  {31'b0, ex_stall}, 32'd0);
    check({tag, "_zero"},   {31'b0, ex_zero_flag}, {31'b0, (exp == 32'd0)});
    check({tag, "_target"}, ex_branch_target_addr, pc + imm);
    check({tag, "_wdata"},  ex_write_data_mem, b);
    @(posedge clk); #1;
    id_ex_valid = 1'b0;
  endtask

  // Issues one M op and follows it to its DONE cycle. perturb scribbles the
  // forwarding sources after the issue cycle; chk4 also checks the radix-16 unit.
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] fa, input logic [31:0] fwd,
                       input bit perturb, input bit chk4, input logic [31:0] exp,
                       input int exp_stall);
    int   n, n4;
    bit   done, done4;
    logic [31:0] res4, e;
    drive_instr(2'b10, 7'b0000001, f3, a, b, 1'b0, $urandom, $urandom);
    forward_a             = fa;
    ex_mem_alu_result_fwd = fwd;
    wb_write_data_fwd     = $urandom;
    exp_q.push_back(exp);
    n = 0; n4 = 0; done = 0; done4 = 0; res4 = '0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (!done4) begin
        if (ex_stall4) n4++;
        else begin done4 = 1; res4 = ex_alu_result4; end
      end
      if (ex_stall) n++;
      else begin
        done = 1;
        e = exp_q.pop_front();
        check({tag, "_res"},  ex_alu_result, e);
        check({tag, "_zero"}, {31'b0, ex_zero_flag}, {31'b0, (e == 32'd0)});
      end
      @(posedge clk); #1;
      if (perturb) begin
        ex_mem_alu_result_fwd = 32'h0000_DEAD;
        wb_write_data_fwd     = 32'h0000_BEEF;
      end
    end
    check({tag, "_stall_cycles"}, n, exp_stall);
    if (chk4) begin
      check({tag, "_r4_stall_cycles"}, n4, 9);
      check({tag, "_r4_res"}, res4, exp);
    end
    id_ex_valid = 1'b0;
    forward_a   = 2'b00;
  endtask

  // Starts a long MUL and stops it at RUN cycle 10 with flush or reset.
  task automatic abort_m(input bit use_reset);
    drive_instr(2'b10, 7'b0000001, 3'b000, 32'h1234, 32'h5678, 1'b0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check(use_reset ? "pre_reset_stall" : "pre_flush_stall", {31'b0, ex_stall}, 32'd1);
    @(posedge clk); #1;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check("reset_async_stall", {31'b0, ex_stall}, 32'd0);
      @(posedge clk); #1;
      id_ex_valid = 1'b0;
      rst_n = 1'b1;
    end else begin
      ex_flush = 1'b1;
      @(negedge clk);
      check("flush_stall", {31'b0, ex_stall}, 32'd0);
      @(posedge clk); #1;
      ex_flush    = 1'b0;
      id_ex_valid = 1'b0;
    end
  endtask

  // Stimulus
  logic [2:0]  f3;
  logic [31:0] a, b, imm, in2, e;
  logic        src, sub;
  logic [2:0]  ops[4] = '{3'd0, 3'd4, 3'd6, 3'd7};

  initial begin
    rst_n = 1'b0; ex_flush = 1'b0;
    ex_mem_alu_result_fwd = '0; wb_write_data_fwd = '0;
    drive_instr(2'b10, 7'b0000000, 3'b000, 32'd5, 32'd7, 1'b0, 32'h20, 32'h100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_add_res",   ex_alu_result, 32'd12);
    check("rst_add_stall", {31'b0, ex_stall}, 32'd0);
    id_ex_funct7 = 7'b0000001;
    @(negedge clk);
    check("rst_mop_stall", {31'b0, ex_stall}, 32'd0);
    @(posedge clk); #1;
    id_ex_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_alu("add", 2'b10, 7'h00, 3'b000, 32'd5, 32'd7, 1'b0, 32'h20, 32'h100, 32'd12);
    run_m("mul", 3'd0, 32'hFFFF_FFFF, 32'd3, 2'b00, 0, 0, 1, 32'hFFFF_FFFD, 33);
    run_m("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd3, 2'b00, 0, 0, 0, 32'h0000_0002, 33);
    run_m("mulh",   3'd1, 32'hFFFF_FFFF, 32'd3, 2'b00, 0, 0, 0, 32'hFFFF_FFFF, 33);
    run_m("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd3, 2'b00, 0, 0, 0, 32'hFFFF_FFFF, 33);
    run_m("div",  3'd4, -32'sd7, 32'd2,   2'b00, 0, 0, 0, 32'hFFFF_FFFD, 33);
    run_m("rem",  3'd6, -32'sd7, 32'd2,   2'b00, 0, 0, 0, 32'hFFFF_FFFF, 33);
    run_m("divu", 3'd5, 32'd100, 32'd7,   2'b00, 0, 0, 0, 32'd14, 33);
    run_m("remu", 3'd7, 32'd100, 32'd7,   2'b00, 0, 0, 0, 32'd2, 33);
    run_m("divu0", 3'd5, 32'h1234, 32'd0, 2'b00, 0, 0, 0, 32'hFFFF_FFFF, 1);
    run_m("remu0", 3'd7, 32'h1234, 32'd0, 2'b00, 0, 0, 0, 32'h1234, 1);
    run_m("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, 32'h8000_0000, 1);
    run_m("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0, 0, 0, 32'h0, 1);
    run_m("fwd_mul", 3'd0, 32'h1111_1111, 32'd7, 2'b01, 32'd6, 1, 0, 32'd42, 33);
    run_alu("sub_zero", 2'b01, 7'h00, 3'b000, 32'd5, 32'd5, 1'b0, 32'h8, 32'h200, 32'd0);

    for (int k = 0; k < 16; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: b = 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_m("rand_m", f3, a, b, 2'b00, 0, 0, 0, ref_m(f3, a, b), ref_stall(f3, a, b));
    end

    for (int k = 0; k < 8; k++) begin
      f3 = ops[$urandom_range(0, 3)];
      sub = 1'($urandom_range(0, 1));
      src = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; imm = $urandom;
      in2 = src ? imm : b;
      case (f3)
        3'd0:    e = sub ? a - in2 : a + in2;
        3'd4:    e = a ^ in2;
        3'd6:    e = a | in2;
        default: e = a & in2;
      endcase
      run_alu("rand_alu", 2'b10, sub ? 7'h20 : 7'h00, f3, a, b, src, imm, $urandom, e);
    end

    abort_m(1'b0);
    run_alu("post_flush_add", 2'b10, 7'h00, 3'b000, 32'd3, 32'd4, 1'b0, 32'h0, 32'h0, 32'd7);
    abort_m(1'b1);
    run_alu("post_reset_add", 2'b10, 7'h00, 3'b000, 32'd1, 32'd1, 1'b0, 32'h4, 32'h40, 32'd2);

    // Final report
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
